// File: rtl/fs_bist_ctrl.sv
// BIST controller for a 1-bit full subtractor: applies four sensitising vectors,
// packs the responses into an 8-bit signature and decodes stuck-at-0 inputs.
module fs_bist_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_d,
  input  logic       dut_bout,
  output logic       tv_a,
  output logic       tv_b,
  output logic       tv_bin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fault_mask,
  output logic       unknown,
  output logic [7:0] signature
);

  typedef enum logic [1:0] {IDLE, APPLY, EVAL, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] vec_idx;
  logic [3:0] cnt;
  logic [2:0] tv;
  logic       launch;
  logic       sample;

  // Vector order 111, 110, 101, 100: A always high, {B,Bin} counts down.
  function automatic logic [2:0] vec_of(input logic [1:0] idx);
    return {1'b1, ~idx[1], ~idx[0]};
  endfunction

  // Returns {pass, unknown, fault_mask}.
  function automatic logic [4:0] decode(input logic [7:0] sig);
    case (sig)
      8'hC2:   return {1'b1, 1'b0, 3'b000};
      8'h7C:   return {1'b0, 1'b0, 3'b100};
      8'h22:   return {1'b0, 1'b0, 3'b010};
      8'h0A:   return {1'b0, 1'b0, 3'b001};
      8'hAA:   return {1'b0, 1'b0, 3'b011};
      8'hCC:   return {1'b0, 1'b0, 3'b110};
      8'hF0:   return {1'b0, 1'b0, 3'b101};
      8'h00:   return {1'b0, 1'b0, 3'b111};
      default: return {1'b0, 1'b1, 3'b000};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = APPLY;
          launch    = 1'b1;
        end
      end
      APPLY: begin
        if (cnt == 4'(SETTLE - 1)) begin
          sample = 1'b1;
          if (vec_idx == 2'd3) state_nxt = EVAL;
        end
      end
      EVAL:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx    <= '0;
      cnt        <= '0;
      tv         <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      unknown    <= 1'b0;
      fault_mask <= '0;
      signature  <= '0;
    end else if (launch) begin
      vec_idx    <= '0;
      cnt        <= '0;
      tv         <= vec_of(2'd0);
      done       <= 1'b0;
      pass       <= 1'b0;
      unknown    <= 1'b0;
      fault_mask <= '0;
      signature  <= '0;
    end else if (state == APPLY) begin
      if (sample) begin
        case (vec_idx)
          2'd0:    signature[7:6] <= {dut_d, dut_bout};
          2'd1:    signature[5:4] <= {dut_d, dut_bout};
          2'd2:    signature[3:2] <= {dut_d, dut_bout};
          default: signature[1:0] <= {dut_d, dut_bout};
        endcase
        cnt <= '0;
        if (vec_idx != 2'd3) begin
          vec_idx <= vec_idx + 2'd1;
          tv      <= vec_of(vec_idx + 2'd1);
        end else begin
          tv <= '0;
        end
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else if (state == EVAL) begin
      {pass, unknown, fault_mask} <= decode(signature);
      done                        <= 1'b1;
    end
  end

  assign {tv_a, tv_b, tv_bin} = tv;
  assign busy = (state == APPLY) || (state == EVAL);

endmodule

// File: tb/tb_fs_bist_ctrl.sv
// Bench for fs_bist_ctrl: three instances (SETTLE=1,2,3) each driving a behavioural
// subtractor with injectable stuck-at-0 inputs; results checked via a scoreboard.
module tb_fs_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start;
  logic [2:0] sa;
  logic force_ff;

  logic [2:0] tva, tvb, tvbin, dd, db, busy, done, pass, unk;
  logic [2:0][2:0] fm;
  logic [2:0][7:0] sig;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic a, b, c;
    assign a = tva[g] & ~sa[2];
    assign b = tvb[g] & ~sa[1];
    assign c = tvbin[g] & ~sa[0];
    assign dd[g] = force_ff | (a ^ b ^ c);
    assign db[g] = force_ff | ((~a & b) | (~a & c) | (b & c));
    fs_bist_ctrl #(.SETTLE(g + 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]),
      .dut_d(dd[g]), .dut_bout(db[g]),
      .tv_a(tva[g]), .tv_b(tvb[g]), .tv_bin(tvbin[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .fault_mask(fm[g]), .unknown(unk[g]), .signature(sig[g])
    );
  end

  typedef struct {
    logic [7:0] sig;
    logic [2:0] mask;
    logic       pass;
    logic       unk;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] sig_tab(input logic [2:0] m);
    case (m)
      3'b000:  return 8'hC2;
      3'b001:  return 8'h0A;
      3'b010:  return 8'h22;
      3'b011:  return 8'hAA;
      3'b100:  return 8'h7C;
      3'b101:  return 8'hF0;
      3'b110:  return 8'hCC;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push(input logic [2:0] m, input logic ff);
    exp_t e;
    if (ff) begin
      e.sig = 8'hFF; e.mask = 3'b000; e.pass = 1'b0; e.unk = 1'b1;
    end else begin
      e.sig = sig_tab(m); e.mask = m; e.pass = (m == 3'b000); e.unk = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following edge 0.
  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Waits for done, checks latency from edge 0, then pops and compares results.
  task automatic collect(input int k, input int exp_edges);
    int e = 0;
    exp_t x;
    while (done[k] !== 1'b1 && e < 200) begin
      @(negedge clk);
      e++;
    end
    tests++;
    if (done[k] !== 1'b1) begin
      fails++;
      $display("FAIL done_timeout inst=%0d got done=%b want 1", k, done[k]);
      return;
    end else if (e != exp_edges) begin
      fails++;
      $display("FAIL done_latency inst=%0d got %0d want %0d", k, e, exp_edges);
    end
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty inst=%0d got 0 entries want 1", k);
      return;
    end
    x = sb.pop_front();
    tests++;
    if (sig[k] !== x.sig) begin
      fails++; $display("FAIL signature inst=%0d got %h want %h", k, sig[k], x.sig);
    end
    tests++;
    if (fm[k] !== x.mask) begin
      fails++; $display("FAIL fault_mask inst=%0d got %b want %b", k, fm[k], x.mask);
    end
    tests++;
    if (pass[k] !== x.pass) begin
      fails++; $display("FAIL pass inst=%0d got %b want %b", k, pass[k], x.pass);
    end
    tests++;
    if (unk[k] !== x.unk) begin
      fails++; $display("FAIL unknown inst=%0d got %b want %b", k, unk[k], x.unk);
    end
    tests++;
    if (busy[k] !== 1'b0 || {tva[k], tvb[k], tvbin[k]} !== 3'b000) begin
      fails++;
      $display("FAIL done_idle inst=%0d got busy=%b tv=%b want busy=0 tv=000",
               k, busy[k], {tva[k], tvb[k], tvbin[k]});
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({tva[k], tvb[k], tvbin[k], busy[k], done[k], pass[k], unk[k], fm[k], sig[k]} !== 19'd0) begin
        fails++;
        $display("FAIL reset_state inst=%0d got tv=%b busy=%b done=%b pass=%b unk=%b fm=%b sig=%h want all 0",
                 k, {tva[k], tvb[k], tvbin[k]}, busy[k], done[k], pass[k], unk[k], fm[k], sig[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fault_free;
    sa = 3'b000;
    push(3'b000, 1'b0);
    pulse_start(1);
    tests++;
    if (busy[1] !== 1'b1) begin
      fails++; $display("FAIL busy_rise got %b want 1", busy[1]);
    end
    collect(1, 9);
  endtask

  task automatic test_stuck_codes;
    for (int m = 1; m < 8; m++) begin
      sa = 3'(m);
      push(3'(m), 1'b0);
      pulse_start(1);
      collect(1, 9);
    end
    sa = 3'b000;
  endtask

  task automatic test_unknown;
    force_ff = 1'b1;
    push(3'b000, 1'b1);
    pulse_start(1);
    collect(1, 9);
    force_ff = 1'b0;
  endtask

  task automatic test_tv_sequence(input int k);
    int s = k + 1;
    logic [2:0] want;
    push(3'b000, 1'b0);
    pulse_start(k);
    for (int e = 0; e <= 4 * s; e++) begin
      want = (e < 4 * s) ? 3'(3'b111 - 3'(e / s)) : 3'b000;
      tests++;
      if ({tva[k], tvb[k], tvbin[k]} !== want || busy[k] !== 1'b1) begin
        fails++;
        $display("FAIL tv_seq inst=%0d edge=%0d got tv=%b busy=%b want tv=%b busy=1",
                 k, e, {tva[k], tvb[k], tvbin[k]}, busy[k], want);
      end
      start[k] = (e == 1);
      @(negedge clk);
    end
    start[k] = 1'b0;
    collect(k, 0);
  endtask

  task automatic test_reset_mid_run;
    logic saw_done = 1'b0;
    pulse_start(1);
    repeat (4) @(negedge clk);
    tests++;
    if ({tva[1], tvb[1], tvbin[1]} !== 3'b101) begin
      fails++; $display("FAIL vec2_before_reset got %b want 101", {tva[1], tvb[1], tvbin[1]});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tva[1], tvb[1], tvbin[1], busy[1], done[1], pass[1], unk[1], fm[1], sig[1]} !== 19'd0) begin
      fails++;
      $display("FAIL async_reset got tv=%b busy=%b done=%b fm=%b sig=%h want all 0",
               {tva[1], tvb[1], tvbin[1]}, busy[1], done[1], fm[1], sig[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done[1] === 1'b1 || busy[1] === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++; $display("FAIL restart_without_start got activity=1 want 0");
    end
    push(3'b000, 1'b0);
    pulse_start(1);
    collect(1, 9);
  endtask

  task automatic test_back_to_back;
    sa = 3'b010;
    push(3'b010, 1'b0);
    push(3'b010, 1'b0);
    start[1] = 1'b1;
    @(negedge clk);
    collect(1, 9);
    @(negedge clk);
    tests++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart got done=%b busy=%b want done=0 busy=1", done[1], busy[1]);
    end
    start[1] = 1'b0;
    collect(1, 9);
    sa = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 3'b000;
    sa = 3'b000;
    force_ff = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_fault_free;
    test_stuck_codes;
    test_unknown;
    test_tv_sequence(0);
    test_tv_sequence(2);
    test_reset_mid_run;
    test_back_to_back;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
